net_observer: RTL and testbench
===============================

Name: net_observer

Overview:
- Receive-side counterpart to the constant-driven nets in the demo set: samples one asynchronous 1-bit net, synchronizes it, glitch-filters it and reports the accepted level.
- Also reports single-cycle rise/fall strobes and a saturating edge counter.
- Used as the checker at the far end of any driven demo net.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count; legal values >= 2.
- FILTER_LEN, 4, consecutive differing synchronized samples required to accept a new level; legal values >= 1; 1 means no filtering.
- CNT_W, 8, edge counter width; legal values >= 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- net_in  input  1  observed net; asynchronous to clk.
- cnt_clr  input  1  synchronous clear of edge_count and cnt_ovf.
- net_level  output  1  filtered, accepted level of net_in.
- rise_pulse  output  1  one-cycle strobe on an accepted 0->1 change.
- fall_pulse  output  1  one-cycle strobe on an accepted 1->0 change.
- edge_count  output  CNT_W  accepted edges, saturating.
- cnt_ovf  output  1  sticky; set when an edge arrives while edge_count is at its maximum.

Behaviour:
- Reset (async assert, synchronous effect on the next edge after deassert): all synchronizer flops 0, filter count 0, net_level 0, both pulses 0, edge_count 0, cnt_ovf 0.
- Synchronizer: SYNC_STAGES-flop shift chain; s = last stage.
- Filter count fcnt, width clog2(FILTER_LEN) (min 1). Per clock edge:
  - s == net_level -> fcnt <= 0.
  - s != net_level and fcnt == FILTER_LEN-1 -> net_level <= s; fcnt <= 0; rise_pulse <= s; fall_pulse <= ~s.
  - otherwise -> fcnt <= fcnt+1.
- Pulses are registered, high for exactly one cycle, and coincide with the first cycle net_level shows the new value. They are never both high.
- Latency: a clean net_in transition held stable appears on net_level SYNC_STAGES+FILTER_LEN clock edges after the first edge that samples it. With defaults this is 6.
- Glitch rejection: any run of fewer than FILTER_LEN differing samples of s resets fcnt and leaves net_level unchanged.
- FSM view (2 states, implied by net_level):
  - LOW: stays while s==0; after FILTER_LEN consecutive cycles of s==1 -> HIGH with a rise strobe.
  - HIGH: symmetric, with a fall strobe.
- Edge counter, per accepted edge:
  - edge_count < 2^CNT_W-1 -> increment.
  - else -> hold at max and set cnt_ovf.
- cnt_clr, evaluated each edge:
  - cnt_clr=1, no accepted edge -> edge_count <= 0; cnt_ovf <= 0.
  - cnt_clr=1 with an accepted edge in the same cycle -> edge_count <= 1; cnt_ovf <= 0. The edge is not lost.
- Reset mid-filter: everything clears immediately; no pulse is produced for the partial run. After deassert, a net_in already at 1 is re-acquired with full latency and gives a rise strobe.
- No combinational path from any input to any output.

Decomposition:
- Shared constants file net_pkg, for reuse by other demo benches:
  - default SYNC_STAGES, FILTER_LEN, CNT_W;
  - localparam FCNT_W computed from FILTER_LEN;
  - level encodings LVL_LOW=1'b0, LVL_HIGH=1'b1.
- One sub-module, net_sync: parameterized SYNC_STAGES flop chain with async active-high reset to 0. net_observer instantiates it once and holds the filter, strobe and counter logic.

Test Plan (defaults unless noted):
1. rst=1 with net_in=1 -> all outputs 0. Release rst, hold net_in=1 -> net_level rises on the 6th edge after release; rise_pulse high exactly that one cycle; edge_count=1.
2. Settled net_level=1; drive net_in=0 for 3 cycles, then back to 1 -> net_level stays 1, no fall_pulse, edge_count unchanged.
3. 255 clean edges, each held 10 cycles -> edge_count=255, cnt_ovf=0. One more edge -> edge_count=255, cnt_ovf=1. Pulse cnt_clr for 1 cycle -> edge_count=0, cnt_ovf=0.
4. Assert cnt_clr in the same cycle that rise_pulse goes high -> edge_count=1 next cycle, cnt_ovf=0.
5. Toggle net_in 0->1; assert rst at the 3rd filter cycle -> outputs 0 immediately, no rise_pulse. Deassert with net_in=1 -> rise after 6 edges, edge_count=1.
6. Rebuild with FILTER_LEN=1, SYNC_STAGES=3 -> latency 4 edges; a 1-cycle net_in glitch that is captured by the synchronizer is accepted, giving rise_pulse then fall_pulse and edge_count=2.

Source files
------------

// File: rtl/net_pkg.sv
// net_pkg: shared defaults, level encodings and filter-count sizing for net observers
package net_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 4;
    localparam int CNT_W_DEF       = 8;

    function automatic int fcnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int FCNT_W = fcnt_w(FILTER_LEN_DEF);

    localparam logic LVL_LOW  = 1'b0;
    localparam logic LVL_HIGH = 1'b1;

    typedef enum logic {ST_LOW = LVL_LOW, ST_HIGH = LVL_HIGH} lvl_t;
endpackage

// File: rtl/net_sync.sv
// net_sync: STAGES-deep flop chain bringing an asynchronous bit into the clk domain
module net_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};

    assign q = chain[STAGES-1];
endmodule

// File: rtl/net_observer.sv
// net_observer: synchronizes and glitch-filters one async net, with edge strobes and a saturating edge counter
module net_observer
    import net_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             net_in,
    input  logic             cnt_clr,
    output logic             net_level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic             cnt_ovf
);
    localparam int FW = fcnt_w(FILTER_LEN);

    logic             s, acc, sat, ovf_nxt;
    logic [FW-1:0]    fcnt, fcnt_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    lvl_t             state, state_nxt;

    net_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(net_in), .q(s));

    always_comb begin
        acc       = (s != state) && (fcnt == FW'(FILTER_LEN - 1));
        sat       = &edge_count;
        state_nxt = acc ? lvl_t'(s) : state;
        fcnt_nxt  = (s == state || acc) ? '0 : fcnt + 1'b1;
        // a clear coinciding with an accepted edge still counts that edge
        cnt_nxt   = cnt_clr ? (acc ? CNT_W'(1) : '0)
                            : (acc && !sat ? edge_count + 1'b1 : edge_count);
        ovf_nxt   = cnt_clr ? 1'b0 : cnt_ovf | (acc & sat);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= ST_LOW;
            fcnt       <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_count <= '0;
            cnt_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            fcnt       <= fcnt_nxt;
            rise_pulse <= acc & s;
            fall_pulse <= acc & ~s;
            edge_count <= cnt_nxt;
            cnt_ovf    <= ovf_nxt;
        end

    assign net_level = state;
endmodule

// File: tb/tb_net_observer.sv
// tb_net_observer: vector tables and hand sequences checked through an expectation queue
module tb_net_observer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       net_in = 1'b1, cnt_clr = 1'b0, net_in2 = 1'b0, cnt_clr2 = 1'b0;
    logic       lvl, rise, fall, ovf, lvl2, rise2, fall2, ovf2;
    logic [7:0] cnt, cnt2;
    int         checks = 0, failures = 0, row = 0;
    bit         use2 = 1'b0;
    string      tname = "reset";

    typedef struct packed {
        logic       ni, clr, c, lv, ri, fa;
        logic [7:0] cn;
        logic       ov;
    } vec_t;

    typedef struct packed {
        logic       c, lv, ri, fa;
        logic [7:0] cn;
        logic       ov;
    } exp_t;

    exp_t sb[$];

    net_observer dut (
        .clk(clk), .rst(rst), .net_in(net_in), .cnt_clr(cnt_clr),
        .net_level(lvl), .rise_pulse(rise), .fall_pulse(fall),
        .edge_count(cnt), .cnt_ovf(ovf)
    );

    net_observer #(.SYNC_STAGES(3), .FILTER_LEN(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .net_in(net_in2), .cnt_clr(cnt_clr2),
        .net_level(lvl2), .rise_pulse(rise2), .fall_pulse(fall2),
        .edge_count(cnt2), .cnt_ovf(ovf2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string f, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d %s: got=%0d expected=%0d", tname, row, f, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("net_level",  use2 ? lvl2  : lvl,  e.lv);
        chk("rise_pulse", use2 ? rise2 : rise, e.ri);
        chk("fall_pulse", use2 ? fall2 : fall, e.fa);
        chk("edge_count", use2 ? cnt2  : cnt,  e.cn);
        chk("cnt_ovf",    use2 ? ovf2  : ovf,  e.ov);
    endtask

    // called at a negedge: drive, queue expectation, clock once, compare
    task automatic step(input vec_t v);
        exp_t e;
        sb.push_back('{c: v.c, lv: v.lv, ri: v.ri, fa: v.fa, cn: v.cn, ov: v.ov});
        if (use2) begin net_in2 = v.ni; cnt_clr2 = v.clr; end
        else      begin net_in  = v.ni; cnt_clr  = v.clr; end
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        row++;
        if (e.c) chk_all(e);
    endtask

    task automatic hold(input logic ni, input int n);
        for (int i = 0; i < n; i++) step('{ni, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    endtask

    vec_t t1[7] = '{
        '{1, 0, 1, 0, 0, 0, 8'd0, 0}, '{1, 0, 1, 0, 0, 0, 8'd0, 0},
        '{1, 0, 1, 0, 0, 0, 8'd0, 0}, '{1, 0, 1, 0, 0, 0, 8'd0, 0},
        '{1, 0, 1, 0, 0, 0, 8'd0, 0}, '{1, 0, 1, 1, 1, 0, 8'd1, 0},
        '{1, 0, 1, 1, 0, 0, 8'd1, 0}
    };

    vec_t t2[9] = '{
        '{0, 0, 1, 1, 0, 0, 8'd1, 0}, '{0, 0, 1, 1, 0, 0, 8'd1, 0},
        '{0, 0, 1, 1, 0, 0, 8'd1, 0}, '{1, 0, 1, 1, 0, 0, 8'd1, 0},
        '{1, 0, 1, 1, 0, 0, 8'd1, 0}, '{1, 0, 1, 1, 0, 0, 8'd1, 0},
        '{1, 0, 1, 1, 0, 0, 8'd1, 0}, '{1, 0, 1, 1, 0, 0, 8'd1, 0},
        '{1, 0, 1, 1, 0, 0, 8'd1, 0}
    };

    vec_t t6[6] = '{
        '{1, 0, 1, 0, 0, 0, 8'd0, 0}, '{0, 0, 1, 0, 0, 0, 8'd0, 0},
        '{0, 0, 1, 0, 0, 0, 8'd0, 0}, '{0, 0, 1, 1, 1, 0, 8'd1, 0},
        '{0, 0, 1, 0, 0, 1, 8'd2, 0}, '{0, 0, 1, 0, 0, 0, 8'd2, 0}
    };

    initial begin
        repeat (3) @(negedge clk);
        chk_all('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});

        tname = "acquire"; row = 0;
        rst = 1'b0;
        foreach (t1[i]) step(t1[i]);

        tname = "glitch"; row = 0;
        foreach (t2[i]) step(t2[i]);

        tname = "saturate"; row = 0;
        for (int i = 1; i <= 254; i++) begin
            hold(i[0] ? 1'b0 : 1'b1, 9);
            step('{i[0] ? 1'b0 : 1'b1, 1'b0, 1'b1, i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 8'(1 + i), 1'b0});
        end
        hold(1'b0, 5);
        step('{0, 0, 1, 0, 0, 1, 8'd255, 1});
        step('{0, 0, 1, 0, 0, 0, 8'd255, 1});
        step('{0, 1, 1, 0, 0, 0, 8'd0, 0});
        step('{0, 0, 1, 0, 0, 0, 8'd0, 0});

        tname = "clr_on_edge"; row = 0;
        hold(1'b1, 5);
        step('{1, 0, 1, 1, 1, 0, 8'd1, 0});
        hold(1'b1, 4);
        hold(1'b0, 5);
        step('{0, 1, 1, 0, 0, 1, 8'd1, 0});
        step('{0, 0, 1, 0, 0, 0, 8'd1, 0});

        tname = "reset_mid"; row = 0;
        for (int i = 0; i < 4; i++) step('{1, 0, 1, 0, 0, 0, 8'd1, 0});
        rst = 1'b1;
        #1;
        chk_all('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk_all('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
        rst = 1'b0;
        foreach (t1[i]) step(t1[i]);

        tname = "fast_cfg"; row = 0;
        use2 = 1'b1;
        foreach (t6[i]) step(t6[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
